// File: rtl/branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare
//
// Gshare conditional-branch direction predictor. A table of 2**IDX_W
// saturating counters is indexed by the fetch PC index XORed with the global
// branch history (GHR). Prediction is combinational from the counter MSB.
// The GHR is shifted speculatively with each prediction and restored from a
// returned checkpoint when a mispredicted branch resolves.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   stall           freezes table, GHR and miss counter
//   lu_valid        lookup for a conditional branch in fetch
//   lu_pc_idx       PC-derived index bits of the fetched branch
//   pred_taken      predicted direction (counter MSB)
//   pred_idx        hashed table index, carried down the pipeline
//   pred_ghr        GHR before this lookup's shift (recovery checkpoint)
//   up_valid        branch resolved this cycle
//   up_idx          pred_idx returned with the resolving branch
//   up_taken        actual outcome
//   up_mispredict   resolved direction differed from prediction
//   up_ghr          pred_ghr returned with the resolving branch
//   miss_count      saturating count of recovery events
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module branch_predictor_gshare #(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2,
    parameter int GHR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             lu_valid,
    input  logic [IDX_W-1:0] lu_pc_idx,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             up_valid,
    input  logic [IDX_W-1:0] up_idx,
    input  logic             up_taken,
    input  logic             up_mispredict,
    input  logic [GHR_W-1:0] up_ghr,
    output logic [15:0]      miss_count
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] tbl [DEPTH];
    logic [GHR_W-1:0] ghr;
    logic [IDX_W-1:0] ghr_ext;
    logic [CTR_W-1:0] lu_ctr;
    logic [CTR_W-1:0] up_ctr;
    logic [CTR_W-1:0] up_ctr_nxt;
    logic             recover;
    logic [GHR_W-1:0] ghr_spec;
    logic [GHR_W-1:0] ghr_rec;

    // Zero-extend the history to the index width before hashing.
    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr;
    end

    // Lookup reads the table as it stands this cycle; a same-cycle update to
    // the same entry is not bypassed.
    always_comb begin
        pred_idx   = lu_pc_idx ^ ghr_ext;
        lu_ctr     = tbl[pred_idx];
        pred_taken = lu_ctr[CTR_W-1];
        pred_ghr   = ghr;
    end

    always_comb begin
        up_ctr     = tbl[up_idx];
        up_ctr_nxt = up_ctr;
        if (up_taken) begin
            if (up_ctr != CTR_MAX) up_ctr_nxt = up_ctr + CTR_W'(1);
        end else begin
            if (up_ctr != '0) up_ctr_nxt = up_ctr - CTR_W'(1);
        end
    end

    // Shifted history: the truncating cast drops the oldest bit and also
    // covers GHR_W=1, where the new history is just the incoming bit.
    always_comb begin
        recover  = up_valid & up_mispredict;
        ghr_spec = GHR_W'({ghr, pred_taken});
        ghr_rec  = GHR_W'({up_ghr, up_taken});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tbl[i] <= CTR_RST;
            end
            ghr        <= '0;
            miss_count <= '0;
        end else if (!stall) begin
            if (up_valid) begin
                tbl[up_idx] <= up_ctr_nxt;
            end
            // Recovery takes priority over the speculative shift.
            if (recover) begin
                ghr <= ghr_rec;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end else if (lu_valid) begin
                ghr <= ghr_spec;
            end
        end
    end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 Parameter IDX_W, default 4: pattern-table index width; table depth = 2**IDX_W entries.
REQ-002 Parameter CTR_W, default 2: saturating-counter width per entry, legal range 2..4.
REQ-003 Parameter GHR_W, default 4: global-history length, legal range 1..IDX_W.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  pipeline stall; when 1, all state holds.
REQ-007 lu_valid  input  1  lookup request for a conditional branch (opcode 7'b1100011) in fetch.
REQ-008 lu_pc_idx  input  IDX_W  PC-derived index bits of the fetched branch.
REQ-009 pred_taken  output  1  predicted direction for the current lookup.
REQ-010 pred_idx  output  IDX_W  hashed table index used; carried down the pipeline.
REQ-011 pred_ghr  output  GHR_W  GHR value before this lookup's shift; recovery checkpoint.
REQ-012 up_valid  input  1  branch resolved this cycle.
REQ-013 up_idx  input  IDX_W  pred_idx returned with the resolving branch.
REQ-014 up_taken  input  1  actual branch outcome.
REQ-015 up_mispredict  input  1  resolved direction differed from prediction.
REQ-016 up_ghr  input  GHR_W  pred_ghr returned with the resolving branch.
REQ-017 miss_count  output  16  mispredict counter, saturating.

Function
REQ-018 Hash: pred_idx = lu_pc_idx XOR {zeros, ghr}; GHR zero-extended to IDX_W.
REQ-019 Prediction is combinational: pred_taken = MSB of counter at pred_idx, zero added latency.
REQ-020 Lookup reads the pre-update counter value: no bypass of a same-cycle update to the same index.
REQ-021 Counter update on posedge when up_valid=1 and stall=0: up_taken=1 increments, saturating at 2**CTR_W-1; up_taken=0 decrements, saturating at 0.
REQ-022 Exactly one entry, up_idx, changes per update; all other entries hold.
REQ-023 Speculative GHR shift when lu_valid=1, stall=0, and no recovery this cycle: ghr <= {ghr[GHR_W-2:0], pred_taken}; for GHR_W=1, ghr <= pred_taken.
REQ-024 Recovery when up_valid=1, up_mispredict=1, stall=0: ghr <= {up_ghr[GHR_W-2:0], up_taken}.
REQ-025 Same-cycle recovery and lookup: recovery wins; the lookup's speculative shift is dropped.
REQ-026 Same-cycle recovery and update to the same entry is legal; the counter updates per REQ-021.
REQ-027 up_mispredict is ignored when up_valid=0.
REQ-028 miss_count increments by 1 on each recovery event, saturating at 16'hFFFF.
REQ-029 stall=1 holds table, ghr and miss_count; pred_taken, pred_idx and pred_ghr still track inputs combinationally.

Reset
REQ-030 rst_n=0 asynchronously sets every counter to weakly-not-taken, 2**(CTR_W-1)-1 (2'b01 at default).
REQ-031 rst_n=0 asynchronously clears ghr to 0 and miss_count to 0.
REQ-032 Reset values: pred_taken=0, pred_idx=lu_pc_idx, pred_ghr=0 while rst_n=0.
REQ-033 Reset asserted mid-operation discards in-flight history; the first post-reset lookup uses ghr=0.
REQ-034 Updates and lookups are ignored while rst_n=0; normal operation starts at the first posedge after rst_n rises.

Verification
REQ-035 Reset, then lookup idx 4'h3 -> pred_taken=0, pred_idx=4'h3, pred_ghr=4'h0.
REQ-036 Three updates to idx 5, taken -> counter 01->10->11->11 (saturates); pred_taken=1 from the first update onward.
REQ-037 Four taken lookups (ghr ends 4'hF), then lookup lu_pc_idx=4'h0 -> pred_idx=4'hF.
REQ-038 ghr=4'hF, same cycle up_mispredict=1, up_ghr=4'h2, up_taken=0, lu_valid=1 -> ghr=4'h4 next cycle; lookup shift dropped; miss_count=1.
REQ-039 stall=1 with up_valid=1, up_mispredict=1 and lu_valid=1 for 3 cycles -> table, ghr and miss_count unchanged.
REQ-040 Parameter sweep IDX_W=6, CTR_W=3, GHR_W=2 -> reset counter value 3'b011; decrement at 0 stays 0; pred_idx upper 4 bits equal lu_pc_idx.
